// File: rtl/seg_sched.sv
// Display-source scheduler for an 8-digit hex display: round-robin or manual
// selection among four 32-bit sources, with a lock that freezes the shown value.
module seg_sched #(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic        mode,
  input  logic [1:0]  man_sel,
  input  logic        lock,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic [3:0]  hex4,
  output logic [3:0]  hex5,
  output logic [3:0]  hex6,
  output logic [3:0]  hex7,
  output logic [3:0]  hex8,
  output logic [1:0]  cur_src,
  output logic        active,
  output logic [1:0]  state_dbg,   // 0 = IDLE, 1 = SHOW, 2 = FROZEN
  output logic [26:0] timer_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam logic [26:0] TIMER_LAST = 27'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  src, src_nxt;
  logic [26:0] timer, timer_nxt;
  logic [31:0] shown, shown_nxt;
  logic        mode_q;
  logic [31:0] sel_data;
  logic [1:0]  lowest_req;
  logic [1:0]  rr_next;
  logic [1:0]  s1, s2, s3;

  always_comb begin
    case (src)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      2'd2:    sel_data = data2;
      default: sel_data = data3;
    endcase
  end

  always_comb begin
    if (req[0])      lowest_req = 2'd0;
    else if (req[1]) lowest_req = 2'd1;
    else if (req[2]) lowest_req = 2'd2;
    else             lowest_req = 2'd3;
  end

  // Rotating search after the current source; falls back to the current one.
  assign s1 = src + 2'd1;
  assign s2 = src + 2'd2;
  assign s3 = src + 2'd3;

  always_comb begin
    if (req[s1])      rr_next = s1;
    else if (req[s2]) rr_next = s2;
    else if (req[s3]) rr_next = s3;
    else              rr_next = src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    timer_nxt = timer;
    shown_nxt = shown;
    case (state)
      IDLE: begin
        shown_nxt = 32'h0;
        if (mode) begin
          state_nxt = SHOW;
          src_nxt   = man_sel;
          timer_nxt = '0;
        end else if (|req) begin
          state_nxt = SHOW;
          src_nxt   = lowest_req;
          timer_nxt = '0;
        end
      end
      SHOW: begin
        shown_nxt = sel_data;
        if (lock) begin
          state_nxt = FROZEN;
        end else if (mode) begin
          src_nxt   = man_sel;
          timer_nxt = '0;
        end else if (mode_q) begin
          // First auto cycle after manual: keep the source, restart the timer.
          timer_nxt = '0;
        end else if (req == 4'b0000) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (!req[src]) begin
          src_nxt   = rr_next;
          timer_nxt = '0;
        end else if (timer == TIMER_LAST) begin
          src_nxt   = rr_next;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 27'd1;
        end
      end
      FROZEN: begin
        if (!lock) begin
          state_nxt = SHOW;
          timer_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src    <= 2'd0;
      timer  <= '0;
      shown  <= 32'h0;
      mode_q <= 1'b0;
    end else begin
      src    <= src_nxt;
      timer  <= timer_nxt;
      shown  <= shown_nxt;
      mode_q <= mode;
    end
  end

  assign hex1      = shown[31:28];
  assign hex2      = shown[27:24];
  assign hex3      = shown[23:20];
  assign hex4      = shown[19:16];
  assign hex5      = shown[15:12];
  assign hex6      = shown[11:8];
  assign hex7      = shown[7:4];
  assign hex8      = shown[3:0];
  assign cur_src   = src;
  assign active    = (state != IDLE);
  assign state_dbg = state;
  assign timer_dbg = timer;

endmodule

// File: tb/tb_seg_sched.sv
// Bench for seg_sched with HOLD_CYCLES=8: directed scenarios plus a randomized run
// checked every cycle against a rule-level reference model.
module tb_seg_sched;

  localparam int HOLD = 8;
  localparam int M_IDLE = 0, M_SHOW = 1, M_FROZEN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic        mode = 1'b0;
  logic [1:0]  man_sel = 2'd0;
  logic        lock = 1'b0;
  logic [3:0]  hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8;
  logic [1:0]  cur_src;
  logic        active;
  logic [1:0]  state_dbg;
  logic [26:0] timer_dbg;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int          m_st, m_src, m_tmr;
  logic [31:0] m_hex;
  logic        m_prev_mode;

  seg_sched #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(d0), .data1(d1), .data2(d2), .data3(d3),
    .mode(mode), .man_sel(man_sel), .lock(lock),
    .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
    .hex5(hex5), .hex6(hex6), .hex7(hex7), .hex8(hex8),
    .cur_src(cur_src), .active(active),
    .state_dbg(state_dbg), .timer_dbg(timer_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] hex_all();
    return {hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8};
  endfunction

  function automatic logic [31:0] src_data(int s);
    case (s)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // First index with a request, scanning four positions starting at 'start' (mod 4).
  function automatic int first_req(int start, logic [3:0] r, int fallback);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return fallback;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_src = 0; m_tmr = 0; m_hex = '0; m_prev_mode = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using inputs present at the edge.
  task automatic model_edge();
    int st = m_st, src = m_src, tmr = m_tmr;
    logic [31:0] hx = m_hex;
    case (m_st)
      M_IDLE: begin
        hx = '0;
        if (mode) begin st = M_SHOW; src = man_sel; tmr = 0; end
        else if (req != 0) begin st = M_SHOW; src = first_req(0, req, 0); tmr = 0; end
      end
      M_SHOW: begin
        hx = src_data(m_src);
        if (lock) st = M_FROZEN;
        else if (mode) begin src = man_sel; tmr = 0; end
        else if (m_prev_mode) tmr = 0;
        else if (req == 0) begin st = M_IDLE; tmr = 0; end
        else if (!req[m_src]) begin src = first_req(m_src + 1, req, m_src); tmr = 0; end
        else if (m_tmr == HOLD - 1) begin src = first_req(m_src + 1, req, m_src); tmr = 0; end
        else tmr = m_tmr + 1;
      end
      default: begin
        if (!lock) begin st = M_SHOW; tmr = 0; end
      end
    endcase
    m_st = st; m_src = src; m_tmr = tmr; m_hex = hx; m_prev_mode = mode;
  endtask

  // Advance one clock, update the model, then compare the whole output vector.
  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    if ({state_dbg, cur_src, active, timer_dbg, hex_all()} !==
        {2'(m_st), 2'(m_src), (m_st != M_IDLE), 27'(m_tmr), m_hex}) begin
      miscompares++;
      $display("FAIL %s model: got st=%0d src=%0d act=%0b tmr=%0d hex=%h, want st=%0d src=%0d act=%0b tmr=%0d hex=%h",
               tag, state_dbg, cur_src, active, timer_dbg, hex_all(),
               m_st, m_src, (m_st != M_IDLE), m_tmr, m_hex);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; mode = 1'b0; man_sel = 2'd0; lock = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'hF; mode = 1'b0; d0 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({state_dbg, cur_src, active, timer_dbg, hex_all()} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got st=%0d src=%0d act=%0b tmr=%0d hex=%h, want all 0",
               state_dbg, cur_src, active, timer_dbg, hex_all());
    end
    do_reset();
  endtask

  task automatic test_lock_idle();
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("lock_idle");
      vectors++;
      if (active !== 1'b0 || state_dbg !== 2'd0) begin
        miscompares++;
        $display("FAIL lock_idle: got active=%0b state=%0d, want 0/0", active, state_dbg);
      end
    end
  endtask

  task automatic test_auto_rotation();
    int seq[4] = '{0, 1, 3, 0};
    do_reset();
    req = 4'b1011;
    d0 = 32'hAAAA_0000; d1 = 32'h1111_2222; d2 = 32'h5555_5555; d3 = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) begin
      step("auto_rot");
      vectors++;
      if (cur_src !== 2'(seq[i / 8])) begin
        miscompares++;
        $display("FAIL auto_rot_seq i=%0d: got cur_src=%0d, want %0d", i, cur_src, seq[i / 8]);
      end
      if (i == 20) begin
        vectors++;
        if (hex_all() !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("FAIL auto_rot_hex: got %h, want deadbeef", hex_all());
        end
      end
    end
  endtask

  task automatic test_req_drop();
    int n = 0;
    do_reset();
    req = 4'b1011;
    d0 = 32'h0000_0001; d1 = 32'h0000_0002; d3 = 32'h0000_0003;
    while (!(m_st == M_SHOW && m_src == 1 && m_tmr == 3) && n < 40) begin
      step("drop_setup");
      n++;
    end
    vectors++;
    if (n >= 40) begin
      miscompares++;
      $display("FAIL drop_setup: got no cur_src=1/timer=3 within 40 cycles, want reached");
    end
    req = 4'b1001;
    step("req_drop");
    vectors++;
    if (cur_src !== 2'd3 || timer_dbg !== 27'd0) begin
      miscompares++;
      $display("FAIL req_drop: got cur_src=%0d timer=%0d, want 3/0", cur_src, timer_dbg);
    end
    // every request withdrawn
    req = 4'b0000;
    step("all_drop");
    vectors++;
    if (active !== 1'b0 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL all_drop_state: got active=%0b state=%0d, want 0/0", active, state_dbg);
    end
    step("all_drop_hex");
    vectors++;
    if (hex_all() !== 32'h0) begin
      miscompares++;
      $display("FAIL all_drop_hex: got %h, want 00000000", hex_all());
    end
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b0001; d0 = 32'h1234_5678;
    step("lock_enter");
    step("lock_show");
    lock = 1'b1;
    step("lock_set");
    for (int i = 0; i < 20; i++) begin
      d0 = 32'h0; req = 4'($urandom_range(0, 15));
      step("lock_frozen");
      vectors++;
      if (hex_all() !== 32'h1234_5678 || cur_src !== 2'd0) begin
        miscompares++;
        $display("FAIL lock_hold: got hex=%h cur_src=%0d, want 12345678/0", hex_all(), cur_src);
      end
    end
    req = 4'b0001;
    lock = 1'b0;
    step("lock_release");
    vectors++;
    if (timer_dbg !== 27'd0 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL lock_release: got timer=%0d state=%0d, want 0/1", timer_dbg, state_dbg);
    end
  endtask

  task automatic test_manual();
    do_reset();
    mode = 1'b1; man_sel = 2'd2; req = 4'b0000; d2 = 32'hCAFE_F00D;
    step("manual_enter");
    vectors++;
    if (active !== 1'b1 || cur_src !== 2'd2) begin
      miscompares++;
      $display("FAIL manual_enter: got active=%0b cur_src=%0d, want 1/2", active, cur_src);
    end
    for (int i = 0; i < 4; i++) begin
      step("manual_show");
      vectors++;
      if (hex_all() !== 32'hCAFE_F00D || timer_dbg !== 27'd0) begin
        miscompares++;
        $display("FAIL manual_show: got hex=%h timer=%0d, want cafef00d/0", hex_all(), timer_dbg);
      end
    end
    // back to auto: source kept, timer restarts
    mode = 1'b0; req = 4'b0100;
    step("mode_return");
    step("mode_return_next");
    vectors++;
    if (cur_src !== 2'd2 || timer_dbg !== 27'd1) begin
      miscompares++;
      $display("FAIL mode_return: got cur_src=%0d timer=%0d, want 2/1", cur_src, timer_dbg);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0110; d1 = 32'h8765_4321; d2 = 32'h1357_9BDF;
    repeat (5) step("areset_setup");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({state_dbg, cur_src, active, timer_dbg, hex_all()} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got st=%0d src=%0d act=%0b tmr=%0d hex=%h, want all 0",
               state_dbg, cur_src, active, timer_dbg, hex_all());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("reset_release");
    vectors++;
    if (active !== 1'b1 || cur_src !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_release: got active=%0b cur_src=%0d, want 1/1", active, cur_src);
    end
    // reset while frozen
    lock = 1'b1;
    repeat (3) step("areset_frozen");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({state_dbg, cur_src, active, timer_dbg, hex_all()} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_frozen: got st=%0d src=%0d act=%0b tmr=%0d hex=%h, want all 0",
               state_dbg, cur_src, active, timer_dbg, hex_all());
    end
    @(negedge clk);
    rst_n = 1'b1;
    lock = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    req = 4'($urandom_range(0, 15));
    for (int i = 0; i < 1500; i++) begin
      d0 = $urandom(); d1 = $urandom(); d2 = $urandom(); d3 = $urandom();
      if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      if ($urandom_range(0, 7) == 0) man_sel = 2'($urandom_range(0, 3));
      step("random");
    end
  endtask

  initial begin
    test_reset();
    test_lock_idle();
    test_auto_rotation();
    test_req_drop();
    test_lock();
    test_manual();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
